// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant, registered IDLE/SETUP/ACCESS sequencing.
// Optional ACCESS timeout (16 stalled cycles -> error completion) under `APB_ARB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_err,
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e        state_q;
  logic          psel_q, penable_q, pwrite_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic          gnt_q;   // owner of the transfer in flight
  logic          last_q;  // requester granted most recently
  logic [1:0]    done_q, err_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
`ifdef APB_ARB_TIMEOUT_EN
  logic [3:0]    tmo_q;
`endif

  logic [1:0]    elig;
  logic          pick;
  logic          finish;
  logic          fin_err;
  logic [DW-1:0] fin_rdata;

  // A requester completing this cycle must not be re-granted in the same cycle.
  always_comb begin
    elig = {req1_valid & ~done_q[1], req0_valid & ~done_q[0]};
    pick = (&elig) ? ~last_q : elig[1];
  end

  always_comb begin
    finish    = 1'b0;
    fin_err   = pslverr;
    fin_rdata = pwrite_q ? '0 : prdata;
    if (state_q == StAccess) begin
      if (pready) begin
        finish = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
      end else if (tmo_q == 4'hF) begin
        finish    = 1'b1;
        fin_err   = 1'b1;
        fin_rdata = '0;
`endif
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (|elig) begin
            gnt_q    <= pick;
            last_q   <= pick;
            pwrite_q <= pick ? req1_write : req0_write;
            paddr_q  <= pick ? req1_addr  : req0_addr;
            pwdata_q <= pick ? req1_wdata : req0_wdata;
            psel_q   <= 1'b1;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_q     <= '0;
`endif
        end
        StAccess: begin
          if (finish) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= StIdle;
            done_q[gnt_q] <= 1'b1;
            err_q[gnt_q]  <= fin_err;
            if (gnt_q) rdata1_q <= fin_rdata;
            else       rdata0_q <= fin_rdata;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 4'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_apb_master_arb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          pclk = 1'b0;
  logic          preset = 1'b0;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_done, req0_err, req1_done, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb_master_arb #(.DW(DW), .AW(AW)) dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial forever #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave responder: ready after wait_cfg stalled ACCESS cycles.
  int            wait_cfg = 0;
  int            acc_n = 0;
  logic          slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  initial forever begin
    @(negedge pclk);
    if (psel && penable) begin
      pready = (acc_n >= wait_cfg);
      acc_n++;
    end else begin
      pready = 1'b0;
      acc_n  = 0;
    end
    prdata  = slv_rdata;
    pslverr = slv_err & pready;
  end

  // Transaction model: a transfer is 'active' from grant; age 1 = setup, age >= 2 = access.
  logic          m_act = 1'b0;
  int            m_own = 0, m_age = 0, m_wait = 0, m_last = 1;
  logic          m_w = 1'b0;
  logic [AW-1:0] e_paddr = '0;
  logic          e_pwrite = 1'b0;
  logic [DW-1:0] e_pwdata = '0;
  logic [1:0]    e_done = '0, e_err = '0, prev_done = '0, elig = '0;
  logic [DW-1:0] e_rdata [2] = '{'0, '0};

  task automatic model_finish(input logic err, input logic [DW-1:0] rd);
    e_done[m_own]  = 1'b1;
    e_err[m_own]   = err;
    e_rdata[m_own] = rd;
    m_act          = 1'b0;
  endtask

  initial forever begin
    @(posedge pclk or posedge preset);
    if (preset) begin
      m_act = 1'b0; m_own = 0; m_age = 0; m_wait = 0; m_last = 1; m_w = 1'b0;
      e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0; e_done = '0; e_err = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
    end else begin
      prev_done = e_done;
      e_done    = '0;
      e_err     = '0;
      if (m_act) begin
        if (m_age >= 2) begin
          if (pready) model_finish(pslverr, m_w ? '0 : prdata);
          else begin
            m_wait++;
`ifdef APB_ARB_TIMEOUT_EN
            if (m_wait == 16) model_finish(1'b1, '0);
`endif
          end
        end
        m_age++;
      end else begin
        elig = {req1_valid & ~prev_done[1], req0_valid & ~prev_done[0]};
        if (elig != 2'b00) begin
          if (elig == 2'b11) m_own = (m_last == 0) ? 1 : 0;
          else               m_own = elig[1] ? 1 : 0;
          m_last   = m_own;
          m_act    = 1'b1;
          m_age    = 1;
          m_wait   = 0;
          m_w      = (m_own == 1) ? req1_write : req0_write;
          e_pwrite = m_w;
          e_paddr  = (m_own == 1) ? req1_addr : req0_addr;
          e_pwdata = (m_own == 1) ? req1_wdata : req0_wdata;
        end
      end
    end
  end

  initial forever begin
    @(negedge pclk);
    chk("psel", psel, m_act);
    chk("penable", penable, m_act && m_age >= 2);
    chk("paddr", paddr, e_paddr);
    chk("pwrite", pwrite, e_pwrite);
    chk("pwdata", pwdata, e_pwdata);
    chk("req0_done", req0_done, e_done[0]);
    chk("req1_done", req1_done, e_done[1]);
    chk("req0_err", req0_err, e_err[0]);
    chk("req1_err", req1_err, e_err[1]);
    chk("req0_rdata", req0_rdata, e_rdata[0]);
    chk("req1_rdata", req1_rdata, e_rdata[1]);
  end

  // Drives one request starting at the current negedge; returns at the negedge showing done.
  task automatic run_xfer(input int n, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int waits, input logic serr,
                          input logic [DW-1:0] srd, input int drop_at,
                          output int lat, output int psel_n, output int pen_n,
                          output int addr_ok, output logic err_seen, output int other_done);
    wait_cfg = waits; slv_err = serr; slv_rdata = srd;
    lat = 0; psel_n = 0; pen_n = 0; addr_ok = 0; err_seen = 1'b0; other_done = 0;
    if (n == 1) begin
      req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge pclk);
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (psel && paddr == a) addr_ok++;
      if (k == drop_at) begin
        if (n == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
      if ((n == 1) ? req0_done : req1_done) other_done++;
      if ((n == 1) ? req1_done : req0_done) begin
        lat = k;
        err_seen = (n == 1) ? req1_err : req0_err;
        break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  int   lat, ps_n, pe_n, a_ok, od;
  logic es;
  int   order [4];
  int   when [4];
  int   nd, cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    #1 preset = 1'b1;
    @(negedge pclk); @(negedge pclk);
    chk("reset_psel", psel, 1'b0);
    chk("reset_rdata0", req0_rdata, 32'h0);
    #2 preset = 1'b0;
    @(negedge pclk);

    // req0 write, zero wait states
    run_xfer(0, 1'b1, 5'h04, 32'hDEADBEEF, 0, 1'b0, 32'hBAD0BAD0, 0, lat, ps_n, pe_n, a_ok, es, od);
    chk("wr_latency", lat, 3);
    chk("wr_psel_cycles", ps_n, 2);
    chk("wr_penable_cycles", pe_n, 1);
    chk("wr_err", es, 1'b0);
    chk("wr_rdata_zero", req0_rdata, 32'h0);

    // req1 read, two wait states
    run_xfer(1, 1'b0, 5'h04, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0, lat, ps_n, pe_n, a_ok, es, od);
    chk("rd_latency", lat, 5);
    chk("rd_paddr_stable", a_ok, 4);
    chk("rd_rdata", req1_rdata, 32'hDEADBEEF);
    @(negedge pclk);
    chk("rd_done_single", req1_done, 1'b0);
    chk("rd_rdata_hold", req1_rdata, 32'hDEADBEEF);

`ifdef APB_ARB_TIMEOUT_EN
    run_xfer(1, 1'b0, 5'h10, 32'h0, 1000, 1'b0, 32'h55AA55AA, 0, lat, ps_n, pe_n, a_ok, es, od);
    chk("tmo_latency", lat, 18);
    chk("tmo_err", es, 1'b1);
    chk("tmo_rdata", req1_rdata, 32'h0);
    chk("tmo_psel", psel, 1'b0);
    @(negedge pclk);
`endif

    // req0 read with valid dropped during setup: still completes
    run_xfer(0, 1'b0, 5'h08, 32'h0, 1, 1'b0, 32'h12345678, 1, lat, ps_n, pe_n, a_ok, es, od);
    chk("drop_latency", lat, 4);
    chk("drop_rdata", req0_rdata, 32'h12345678);
    @(negedge pclk);

    // req1 write with slave error; req0 untouched
    run_xfer(1, 1'b1, 5'h0C, 32'hCAFEF00D, 0, 1'b1, 32'h0, 0, lat, ps_n, pe_n, a_ok, es, od);
    chk("serr_latency", lat, 3);
    chk("serr_err", es, 1'b1);
    chk("serr_req0_done", od, 0);
    chk("serr_req0_err", req0_err, 1'b0);
    chk("serr_req0_rdata", req0_rdata, 32'h12345678);
    slv_err = 1'b0;

    // Reset, then both requesters held: strict alternation starting with req0
    #2 preset = 1'b1;
    @(negedge pclk);
    #2 preset = 1'b0;
    @(negedge pclk);
    wait_cfg = 0; slv_rdata = 32'h0F0F0F0F;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 5'h01;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 5'h02;
    nd = 0;
    for (cyc = 1; cyc <= 40 && nd < 4; cyc++) begin
      @(negedge pclk);
      if (req0_done) begin order[nd] = 0; when[nd] = cyc; nd++; end
      else if (req1_done) begin order[nd] = 1; when[nd] = cyc; nd++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", nd, 4);
    chk("rr_first", order[0], 0);
    chk("rr_second", order[1], 1);
    chk("rr_third", order[2], 0);
    chk("rr_fourth", order[3], 1);
    chk("rr_first_latency", when[0], 3);
    chk("rr_gap", when[1] - when[0], 3);
    chk("rr_gap2", when[3] - when[2], 3);

    // Reset during ACCESS of a req0 transfer aborts it silently
    @(negedge pclk);
    wait_cfg = 5;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 5'h08;
    for (int k = 0; k < 10 && !(psel && penable); k++) @(negedge pclk);
    chk("abort_in_access", penable, 1'b1);
    #2 preset = 1'b1;
    #1;
    chk("abort_psel", psel, 1'b0);
    chk("abort_penable", penable, 1'b0);
    req0_valid = 1'b0;
    @(negedge pclk);
    #2 preset = 1'b0;
    wait_cfg = 0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      if (req0_done || req1_done) nd++;
    end
    chk("abort_no_done", nd, 0);
    req0_valid = 1'b1; req0_addr = 5'h03;
    req1_valid = 1'b1; req1_addr = 5'h04;
    nd = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (req0_done) begin nd = 0; break; end
      if (req1_done) begin nd = 1; break; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("abort_then_req0_first", nd, 0);
    repeat (6) @(negedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
